// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative MUL/DIV divider: FSM encodings and
// exception-cause constants also used by the CPU MUL/DIV decode.
package iter_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_ZERO = 2'd3
  } div_state_e;

  // Cause codes raised by the MUL/DIV path towards the exception unit.
  localparam logic [3:0] CAUSE_NONE     = 4'd0;
  localparam logic [3:0] CAUSE_DIV_ZERO = 4'd1;
  localparam logic [3:0] CAUSE_ABORTED  = 4'd2;

endpackage

// File: rtl/iter_divider_div_step.sv
// One combinational restoring-division step: shift {rem,quo} left by one,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_neg;
  logic             w_unused_bits;

  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  // Extra top bit acts as the borrow / sign of the trial subtraction.
  assign w_diff  = {1'b0, w_shift} - {2'b00, i_divisor};
  assign w_neg   = w_diff[WIDTH+1];

  // A kept difference is always below the divisor, and a restored value is
  // below the divisor too, so WIDTH bits hold the new remainder either way.
  assign o_rem = w_neg ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_neg};

  assign w_unused_bits = ^{w_diff[WIDTH], w_shift[WIDTH]};

endmodule

// File: rtl/iter_divider.sv
// Iterative restoring divider (DIV/DIVU) retiring STEPS quotient bits per
// cycle, with abort and divide-by-zero bypass. Results feed HI/LO on done.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int ITERS = WIDTH / STEPS;
  localparam int CW    = $clog2(ITERS) + 1;
  // count tracks RUN edges; the last one moves to FIX
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  div_state_e       r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic [WIDTH-1:0] r_q, r_r;
  logic             r_qneg, r_rneg, r_done, r_dbz;

  logic             w_accept, w_zero, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH-1:0] w_rem [STEPS+1];
  logic [WIDTH-1:0] w_quo [STEPS+1];

  assign w_a_neg  = i_is_signed & i_dividend[WIDTH-1];
  assign w_b_neg  = i_is_signed & i_divisor[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~i_dividend + 1'b1) : i_dividend;
  assign w_b_mag  = w_b_neg ? (~i_divisor + 1'b1) : i_divisor;
  assign w_zero   = (i_divisor == '0);
  // abort in IDLE suppresses a simultaneous start
  assign w_accept = (r_state == ST_IDLE) & i_start & ~i_abort;

  // STEPS restoring steps chained within one cycle
  assign w_rem[0] = r_rem;
  assign w_quo[0] = r_quo;
  for (genvar g = 0; g < STEPS; g++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem     (w_rem[g]),
      .i_quo     (w_quo[g]),
      .i_divisor (r_dvs),
      .o_rem     (w_rem[g+1]),
      .o_quo     (w_quo[g+1])
    );
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; abort returns any active state to IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next = w_zero ? ST_ZERO : ST_RUN;
      ST_RUN: begin
        if (i_abort)             w_next = ST_IDLE;
        else if (r_cnt == LAST)  w_next = ST_FIX;
      end
      ST_FIX:  w_next = ST_IDLE;
      ST_ZERO: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture, iteration, sign fix-up and result registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_q    <= '0;
      r_r    <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: if (w_accept) begin
          // raw dividend is kept for the divide-by-zero result
          r_quo  <= w_zero ? i_dividend : w_a_mag;
          r_dvs  <= w_b_mag;
          r_rem  <= '0;
          r_cnt  <= '0;
          r_qneg <= w_a_neg ^ w_b_neg;
          r_rneg <= w_a_neg;
          r_dbz  <= 1'b0;
        end
        ST_RUN: if (!i_abort) begin
          r_rem <= w_rem[STEPS];
          r_quo <= w_quo[STEPS];
          r_cnt <= r_cnt + CW'(1);
        end
        ST_FIX: if (!i_abort) begin
          r_q    <= r_qneg ? (~r_quo + 1'b1) : r_quo;
          r_r    <= r_rneg ? (~r_rem + 1'b1) : r_rem;
          r_done <= 1'b1;
        end
        ST_ZERO: if (!i_abort) begin
          r_q    <= '1;
          r_r    <= r_quo;
          r_dbz  <= 1'b1;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = r_done;
  assign o_quotient    = r_q;
  assign o_remainder   = r_r;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: directed vectors on a STEPS=1 and a
// STEPS=4 instance; monitors pop expected results whenever done pulses.
module tb_iter_divider;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  logic clk, rst_n;

  logic        s1_start, s1_sgn, s1_abort;
  logic [31:0] s1_a, s1_b;
  logic        b1_busy, d1_done, z1;
  logic [31:0] q1, r1;

  logic        s4_start, s4_sgn, s4_abort;
  logic [31:0] s4_a, s4_b;
  logic        b4_busy, d4_done, z4;
  logic [31:0] q4, r4;

  exp_t sb1[$];
  exp_t sb4[$];
  exp_t e1, e4;
  int   total = 0;
  int   bad   = 0;

  iter_divider #(.WIDTH(32), .STEPS(1)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .i_start(s1_start), .i_is_signed(s1_sgn),
    .i_abort(s1_abort), .i_dividend(s1_a), .i_divisor(s1_b),
    .o_busy(b1_busy), .o_done(d1_done), .o_quotient(q1),
    .o_remainder(r1), .o_div_by_zero(z1)
  );

  iter_divider #(.WIDTH(32), .STEPS(4)) dut4 (
    .i_clk(clk), .i_rst(rst_n), .i_start(s4_start), .i_is_signed(s4_sgn),
    .i_abort(s4_abort), .i_dividend(s4_a), .i_divisor(s4_b),
    .o_busy(b4_busy), .o_done(d4_done), .o_quotient(q4),
    .o_remainder(r4), .o_div_by_zero(z4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the STEPS=1 instance
  always @(negedge clk) begin
    if (rst_n && d1_done) begin
      if (sb1.size() == 0) begin
        total++; bad++;
        $display("FAIL d1_unexpected_done: got q=%h r=%h expected no done", q1, r1);
      end else begin
        e1 = sb1.pop_front();
        chk("d1_q", q1, e1.q);
        chk("d1_r", r1, e1.r);
        chk("d1_dbz", {31'b0, z1}, {31'b0, e1.z});
      end
    end
  end

  // Monitor for the STEPS=4 instance
  always @(negedge clk) begin
    if (rst_n && d4_done) begin
      if (sb4.size() == 0) begin
        total++; bad++;
        $display("FAIL d4_unexpected_done: got q=%h r=%h expected no done", q4, r4);
      end else begin
        e4 = sb4.pop_front();
        chk("d4_q", q4, e4.q);
        chk("d4_r", r4, e4.r);
        chk("d4_dbz", {31'b0, z4}, {31'b0, e4.z});
      end
    end
  end

  // Issue one operation, push its expectation, count busy cycles.
  // b2b=1 drives start in the current (done) cycle instead of the next one.
  task automatic op(input int u, input bit b2b, input logic sg,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] eq, input logic [31:0] er,
                    input logic ez, input int eb);
    exp_t e;
    int   nb;
    e  = '{eq, er, ez};
    nb = 0;
    if (u == 1) sb1.push_back(e); else sb4.push_back(e);
    if (!b2b) @(negedge clk);
    if (u == 1) begin s1_start = 1'b1; s1_sgn = sg; s1_a = a; s1_b = b; end
    else        begin s4_start = 1'b1; s4_sgn = sg; s4_a = a; s4_b = b; end
    @(posedge clk); #1;
    s1_start = 1'b0; s4_start = 1'b0;
    @(negedge clk);
    while (((u == 1) ? b1_busy : b4_busy) && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    chk($sformatf("busy_cycles_u%0d", u), 32'(nb), 32'(eb));
  endtask

  initial begin
    rst_n = 1'b0;
    s1_start = 0; s1_sgn = 0; s1_abort = 0; s1_a = 0; s1_b = 0;
    s4_start = 0; s4_sgn = 0; s4_abort = 0; s4_a = 0; s4_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_q1", q1, 32'h0);
    chk("rst_r1", r1, 32'h0);
    chk("rst_flags1", {29'b0, b1_busy, d1_done, z1}, 32'h0);
    chk("rst_flags4", {29'b0, b4_busy, d4_done, z4}, 32'h0);
    rst_n = 1'b1;

    op(1, 0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 33);
    op(1, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 33);
    op(1, 0, 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, 33);

    // abort at count 10 with an ignored start while busy
    @(negedge clk);
    s1_start = 1; s1_sgn = 0; s1_a = 32'd1000; s1_b = 32'd3;
    @(posedge clk); #1 s1_start = 0;
    repeat (5) @(posedge clk);
    #1 s1_start = 1; s1_a = 32'd5; s1_b = 32'd1;
    @(posedge clk); #1 s1_start = 0;
    repeat (4) @(posedge clk);
    @(negedge clk); s1_abort = 1;
    @(posedge clk); #1 s1_abort = 0;
    @(negedge clk);
    chk("abort_busy", {31'b0, b1_busy}, 32'h0);
    repeat (3) @(negedge clk);
    chk("abort_q_held", q1, 32'hFFFF_FFFD);
    chk("abort_r_held", r1, 32'd1);

    // start and abort together in IDLE: nothing accepted
    @(negedge clk); s1_start = 1; s1_abort = 1; s1_a = 32'd9; s1_b = 32'd3;
    @(posedge clk); #1 s1_start = 0; s1_abort = 0;
    @(negedge clk);
    chk("idle_abort_busy", {31'b0, b1_busy}, 32'h0);

    op(1, 0, 0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1, 1);
    repeat (2) @(negedge clk);
    chk("dbz_held", {31'b0, z1}, 32'h1);
    op(1, 0, 1, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1, 1);
    op(1, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 0, 33);
    op(1, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 33);
    op(1, 0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 33);

    // STEPS=4: 9 busy cycles, then a back-to-back start in the done cycle
    op(4, 0, 0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 0, 9);
    op(4, 1, 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 9);

    repeat (4) @(negedge clk);
    chk("sb1_drained", 32'(sb1.size()), 32'h0);
    chk("sb4_drained", 32'(sb4.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
